// File: rtl/tm_pkg.sv
// Shared defaults and FSM encoding for the class argmax block.
package tm_pkg;

    localparam int INT_SIZE    = 32;
    localparam int NUM_CLASSES = 10;
    localparam int CLASS_W     = 4;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } argmax_state_e;

endpackage

// File: rtl/tm_max_cmp.sv
// Combinational signed compare-and-select: keeps the current best unless the
// candidate is strictly greater (ties favour the earlier, lower index) or the
// caller forces the candidate in (first sample of a collection).
module tm_max_cmp #(
    parameter int INT_SIZE = 32,
    parameter int CLASS_W  = 4
) (
    input  logic                       force_take,
    input  logic signed [INT_SIZE-1:0] cur_sum,
    input  logic        [CLASS_W-1:0]  cur_class,
    input  logic signed [INT_SIZE-1:0] cand_sum,
    input  logic        [CLASS_W-1:0]  cand_class,
    output logic signed [INT_SIZE-1:0] max_sum,
    output logic        [CLASS_W-1:0]  max_class
);

    logic take;

    assign take      = force_take || (cand_sum > cur_sum);
    assign max_sum   = take ? cand_sum   : cur_sum;
    assign max_class = take ? cand_class : cur_class;

endmodule

// File: rtl/class_argmax.sv
// Collects NUM_CLASSES signed class sums in order and reports the index and
// value of the largest one, one cycle after the final sample.
module class_argmax #(
    parameter int NUM_CLASSES = tm_pkg::NUM_CLASSES,
    parameter int INT_SIZE    = tm_pkg::INT_SIZE,
    parameter int CLASS_W     = tm_pkg::CLASS_W
) (
    input  logic                       clk,
    input  logic                       rst_flag,
    input  logic                       start,
    input  logic                       sum_valid,
    input  logic signed [INT_SIZE-1:0] sum_in,
    output logic                       busy,
    output logic                       pred_valid,
    output logic        [CLASS_W-1:0]  pred_class,
    output logic signed [INT_SIZE-1:0] pred_sum,
    output logic                       err
);

    import tm_pkg::*;

    localparam logic [CLASS_W-1:0] LAST_IDX = CLASS_W'(NUM_CLASSES - 1);

    argmax_state_e              state_q, state_d;
    logic [CLASS_W-1:0]         idx_q, idx_d;
    logic signed [INT_SIZE-1:0] best_sum_q, best_sum_d;
    logic [CLASS_W-1:0]         best_class_q, best_class_d;
    logic signed [INT_SIZE-1:0] pred_sum_q, pred_sum_d;
    logic [CLASS_W-1:0]         pred_class_q, pred_class_d;
    logic                       err_q, err_d;
    logic signed [INT_SIZE-1:0] cmp_sum;
    logic [CLASS_W-1:0]         cmp_class;

    tm_max_cmp #(
        .INT_SIZE (INT_SIZE),
        .CLASS_W  (CLASS_W)
    ) u_cmp (
        .force_take (idx_q == '0),
        .cur_sum    (best_sum_q),
        .cur_class  (best_class_q),
        .cand_sum   (sum_in),
        .cand_class (idx_q),
        .max_sum    (cmp_sum),
        .max_class  (cmp_class)
    );

    // State and datapath registers; reset wipes every partial result.
    always_ff @(posedge clk or posedge rst_flag) begin
        if (rst_flag) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            best_sum_q   <= '0;
            best_class_q <= '0;
            pred_sum_q   <= '0;
            pred_class_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            best_sum_q   <= best_sum_d;
            best_class_q <= best_class_d;
            pred_sum_q   <= pred_sum_d;
            pred_class_q <= pred_class_d;
            err_q        <= err_d;
        end
    end

    // Next-state and datapath update; start always begins a fresh collection.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        best_sum_d   = best_sum_q;
        best_class_d = best_class_q;
        pred_sum_d   = pred_sum_q;
        pred_class_d = pred_class_q;
        err_d        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_COLLECT;
                    idx_d        = '0;
                    best_sum_d   = '0;
                    best_class_d = '0;
                end
            end
            S_COLLECT: begin
                if (start) begin
                    // Abort: restart at class 0, same-cycle sample is dropped.
                    err_d        = 1'b1;
                    idx_d        = '0;
                    best_sum_d   = '0;
                    best_class_d = '0;
                end else if (sum_valid) begin
                    best_sum_d   = cmp_sum;
                    best_class_d = cmp_class;
                    if (idx_q == LAST_IDX) begin
                        state_d      = S_DONE;
                        pred_sum_d   = cmp_sum;
                        pred_class_d = cmp_class;
                    end else begin
                        idx_d = idx_q + CLASS_W'(1);
                    end
                end
            end
            S_DONE: begin
                if (start) begin
                    state_d      = S_COLLECT;
                    idx_d        = '0;
                    best_sum_d   = '0;
                    best_class_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy       = (state_q == S_COLLECT);
    assign pred_valid = (state_q == S_DONE);
    assign pred_class = pred_class_q;
    assign pred_sum   = pred_sum_q;
    assign err        = err_q;

endmodule

// File: tb/tb_class_argmax.sv
// Directed bench for class_argmax with NUM_CLASSES=4.
module tb_class_argmax;

    logic        clk = 1'b0;
    logic        rst_flag;
    logic        start;
    logic        sum_valid;
    logic [31:0] sum_in;
    logic        busy;
    logic        pred_valid;
    logic [3:0]  pred_class;
    logic [31:0] pred_sum;
    logic        err;

    int checks   = 0;
    int failures = 0;
    int err_cnt  = 0;
    int pv_cnt   = 0;

    class_argmax #(
        .NUM_CLASSES (4),
        .INT_SIZE    (32),
        .CLASS_W     (4)
    ) dut (
        .clk        (clk),
        .rst_flag   (rst_flag),
        .start      (start),
        .sum_valid  (sum_valid),
        .sum_in     (sum_in),
        .busy       (busy),
        .pred_valid (pred_valid),
        .pred_class (pred_class),
        .pred_sum   (pred_sum),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled away from the active edge.
    always @(negedge clk) begin
        if (err)        err_cnt++;
        if (pred_valid) pv_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [31:0] v);
        sum_valid = 1'b1;
        sum_in    = v;
        tick();
        sum_valid = 1'b0;
        sum_in    = '0;
    endtask

    task automatic run4(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [31:0] d);
        send(a); send(b); send(c); send(d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pv0, er0;
        rst_flag = 1'b1; start = 1'b0; sum_valid = 1'b0; sum_in = '0;
        tick(); tick();
        check("rst_busy",  {31'd0, busy},       32'd0);
        check("rst_pv",    {31'd0, pred_valid}, 32'd0);
        check("rst_err",   {31'd0, err},        32'd0);
        check("rst_class", {28'd0, pred_class}, 32'd0);
        check("rst_sum",   pred_sum,            32'd0);
        rst_flag = 1'b0;
        tick();

        // Basic: 5,-3,12,7 -> class 2, sum 12
        do_start();
        check("t1_busy", {31'd0, busy}, 32'd1);
        run4(32'd5, -32'sd3, 32'd12, 32'd7);
        check("t1_pv",    {31'd0, pred_valid}, 32'd1);
        check("t1_class", {28'd0, pred_class}, 32'd2);
        check("t1_sum",   pred_sum,            32'd12);
        tick();
        check("t1_pv_off",  {31'd0, pred_valid}, 32'd0);
        check("t1_idle",    {31'd0, busy},       32'd0);
        check("t1_hold",    {28'd0, pred_class}, 32'd2);

        // Signed compare and tie rule: -8,-2,-2,-9 -> class 1, sum -2
        do_start();
        run4(-32'sd8, -32'sd2, -32'sd2, -32'sd9);
        check("t2_pv",    {31'd0, pred_valid}, 32'd1);
        check("t2_class", {28'd0, pred_class}, 32'd1);
        check("t2_sum",   pred_sum,            32'hFFFF_FFFE);
        tick();

        // Abort by start after two samples, then 0,0,0,40
        er0 = err_cnt;
        do_start();
        send(32'd50); send(32'd60);
        start = 1'b1; sum_valid = 1'b1; sum_in = 32'd99;
        tick();
        start = 1'b0; sum_valid = 1'b0;
        check("t3_err",  {31'd0, err},  32'd1);
        check("t3_busy", {31'd0, busy}, 32'd1);
        run4(32'd0, 32'd0, 32'd0, 32'd40);
        check("t3_class", {28'd0, pred_class}, 32'd3);
        check("t3_sum",   pred_sum,            32'd40);
        tick();
        check("t3_errcnt", 32'(err_cnt - er0), 32'd1);

        // Async reset between samples 2 and 3
        pv0 = pv_cnt; er0 = err_cnt;
        do_start();
        send(32'd3); send(32'd4);
        rst_flag = 1'b1;
        #1;
        check("t4_class", {28'd0, pred_class}, 32'd0);
        check("t4_sum",   pred_sum,            32'd0);
        check("t4_busy",  {31'd0, busy},       32'd0);
        tick();
        rst_flag = 1'b0;
        send(32'd8); send(32'd9);
        tick(); tick();
        check("t4_nopv",  32'(pv_cnt - pv0),   32'd0);
        check("t4_noerr", 32'(err_cnt - er0),  32'd0);
        do_start();
        run4(32'd5, -32'sd3, 32'd12, 32'd7);
        check("t4_pv",     {31'd0, pred_valid}, 32'd1);
        check("t4_class2", {28'd0, pred_class}, 32'd2);
        check("t4_sum2",   pred_sum,            32'd12);
        tick();

        // Most-negative sums with gaps; IDLE sum_valid ignored
        pv0 = pv_cnt;
        send(32'd100); send(32'd200);
        check("t5_idle_busy", {31'd0, busy}, 32'd0);
        check("t5_idle_pv",   32'(pv_cnt - pv0), 32'd0);
        do_start();
        for (int i = 0; i < 4; i++) begin
            send(32'h8000_0000);
            if (i < 3) begin
                tick(); tick(); tick();
                check("t5_gap_busy", {31'd0, busy}, 32'd1);
            end
        end
        check("t5_pv",    {31'd0, pred_valid}, 32'd1);
        check("t5_class", {28'd0, pred_class}, 32'd0);
        check("t5_sum",   pred_sum,            32'h8000_0000);
        tick();

        // start in the DONE cycle
        er0 = err_cnt;
        do_start();
        run4(32'd1, 32'd2, 32'd3, 32'd9);
        start = 1'b1;
        check("t6_pv",    {31'd0, pred_valid}, 32'd1);
        check("t6_class", {28'd0, pred_class}, 32'd3);
        tick();
        start = 1'b0;
        check("t6_busy", {31'd0, busy}, 32'd1);
        check("t6_err",  {31'd0, err},  32'd0);
        run4(32'd6, 32'd6, 32'd1, 32'd2);
        check("t6_class2", {28'd0, pred_class}, 32'd0);
        check("t6_sum2",   pred_sum,            32'd6);
        tick();
        check("t6_errcnt", 32'(err_cnt - er0), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
